// File: rtl/etapa_reg_pipeline_pkg.sv
// Shared definitions for the pipeline stage register: state encoding,
// skid mode selectors and the occupancy helper.
package etapa_pkg;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

   localparam int SKID_SINGLE = 0;
   localparam int SKID_DOUBLE = 1;

   typedef enum logic [1:0] {
      ST_EMPTY = EMPTY,
      ST_ONE   = ONE,
      ST_TWO   = TWO
   } state_t;

   function automatic logic [1:0] occupancy(input state_t s);
      return s;
   endfunction

endpackage

// File: rtl/etapa_reg_pipeline_if.sv
// Upstream/downstream handshake bundle of the pipeline stage register.
interface etapa_reg_pipeline_if #(
   parameter int NBITS = 32,
   parameter int CBITS = 8
);
   logic             i_enable;
   logic             i_flush;
   logic             i_valid;
   logic             o_ready;
   logic [NBITS-1:0] i_data;
   logic [CBITS-1:0] i_ctrl;
   logic             o_valid;
   logic             i_ready;
   logic [NBITS-1:0] o_data;
   logic [CBITS-1:0] o_ctrl;
   logic [1:0]       o_count;

   modport slave (
      input  i_enable, i_flush, i_valid, i_data, i_ctrl, i_ready,
      output o_ready, o_valid, o_data, o_ctrl, o_count
   );

   modport master (
      output i_enable, i_flush, i_valid, i_data, i_ctrl, i_ready,
      input  o_ready, o_valid, o_data, o_ctrl, o_count
   );
endinterface

// File: rtl/etapa_reg_pipeline_entry.sv
// One payload+control register slot; control bits can be cleared on their
// own so a bubble never carries write enables while data is retained.
module etapa_reg_entry #(
   parameter int NBITS = 32,
   parameter int CBITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clear_ctrl,
   input  logic [NBITS-1:0] d_data,
   input  logic [CBITS-1:0] d_ctrl,
   output logic [NBITS-1:0] q_data,
   output logic [CBITS-1:0] q_ctrl
);

   // Slot storage: reset clears all, load captures, clear_ctrl drops control only
   always_ff @(posedge clk) begin
      if (rst) begin
         q_data <= '0;
         q_ctrl <= '0;
      end else if (load) begin
         q_data <= d_data;
         q_ctrl <= d_ctrl;
      end else if (clear_ctrl) begin
         q_ctrl <= '0;
      end
   end

endmodule

// File: rtl/etapa_reg_pipeline.sv
// Pipeline stage register with valid/ready handshake, optional skid slot,
// flush-to-bubble and debug-step enable.
module etapa_reg_pipeline
   import etapa_pkg::*;
#(
   parameter int NBITS = 32,
   parameter int CBITS = 8,
   parameter int SKID  = 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   etapa_reg_pipeline_if.slave  bus
);

   state_t           state;
   logic             valid;
   logic [1:0]       count;
   logic             ready;
   logic             accept;
   logic             drain;
   logic             m_load;
   logic             m_clr;
   logic             m_from_s;
   logic             s_load;
   logic             s_clr;
   logic [NBITS-1:0] m_data;
   logic [CBITS-1:0] m_ctrl;
   logic [NBITS-1:0] s_data;
   logic [CBITS-1:0] s_ctrl;
   logic [NBITS-1:0] m_d_data;
   logic [CBITS-1:0] m_d_ctrl;

   // With a skid slot, ready depends only on registered state, never on i_ready
   generate
      if (SKID == SKID_DOUBLE) begin : g_ready_skid
         assign ready = ~i_reset & bus.i_enable & ~bus.i_flush & (state != ST_TWO);
      end else begin : g_ready_single
         assign ready = ~i_reset & bus.i_enable & ~bus.i_flush & (~valid | bus.i_ready);
      end
   endgenerate

   assign accept = bus.i_valid & ready;
   assign drain  = valid & bus.i_ready & bus.i_enable & ~bus.i_flush;

   // Slot load/clear decisions for the current cycle
   always_comb begin
      m_load   = 1'b0;
      m_clr    = 1'b0;
      m_from_s = 1'b0;
      s_load   = 1'b0;
      s_clr    = 1'b0;
      if (bus.i_flush) begin
         m_clr = 1'b1;
         s_clr = 1'b1;
      end else if (bus.i_enable) begin
         case (state)
            ST_EMPTY: begin
               m_load = accept;
            end
            ST_ONE: begin
               if (accept & drain) begin
                  m_load = 1'b1;
               end else if (accept) begin
                  s_load = 1'b1;
               end else if (drain) begin
                  m_clr = 1'b1;
               end else begin
                  m_load = 1'b0;
               end
            end
            ST_TWO: begin
               if (drain) begin
                  m_load   = 1'b1;
                  m_from_s = 1'b1;
                  s_clr    = 1'b1;
               end else begin
                  m_load = 1'b0;
               end
            end
            default: begin
               m_clr = 1'b1;
               s_clr = 1'b1;
            end
         endcase
      end else begin
         m_load = 1'b0;
      end
   end

   assign m_d_data = m_from_s ? s_data : bus.i_data;
   assign m_d_ctrl = m_from_s ? s_ctrl : bus.i_ctrl;

   // Occupancy FSM; valid and count are registered alongside the state
   always_ff @(posedge i_clk) begin
      if (i_reset || bus.i_flush) begin
         state <= ST_EMPTY;
         valid <= 1'b0;
         count <= 2'd0;
      end else if (bus.i_enable) begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state <= ST_ONE;
                  valid <= 1'b1;
                  count <= occupancy(ST_ONE);
               end
            end
            ST_ONE: begin
               if (accept && !drain && SKID == SKID_DOUBLE) begin
                  state <= ST_TWO;
                  count <= occupancy(ST_TWO);
               end else if (drain && !accept) begin
                  state <= ST_EMPTY;
                  valid <= 1'b0;
                  count <= occupancy(ST_EMPTY);
               end
            end
            ST_TWO: begin
               if (drain) begin
                  state <= ST_ONE;
                  count <= occupancy(ST_ONE);
               end
            end
            default: begin
               state <= ST_EMPTY;
               valid <= 1'b0;
               count <= 2'd0;
            end
         endcase
      end
   end

   etapa_reg_entry #(.NBITS(NBITS), .CBITS(CBITS)) u_m (
      .clk        (i_clk),
      .rst        (i_reset),
      .load       (m_load),
      .clear_ctrl (m_clr),
      .d_data     (m_d_data),
      .d_ctrl     (m_d_ctrl),
      .q_data     (m_data),
      .q_ctrl     (m_ctrl)
   );

   generate
      if (SKID == SKID_DOUBLE) begin : g_skid
         etapa_reg_entry #(.NBITS(NBITS), .CBITS(CBITS)) u_s (
            .clk        (i_clk),
            .rst        (i_reset),
            .load       (s_load),
            .clear_ctrl (s_clr),
            .d_data     (bus.i_data),
            .d_ctrl     (bus.i_ctrl),
            .q_data     (s_data),
            .q_ctrl     (s_ctrl)
         );
      end else begin : g_no_skid
         assign s_data = '0;
         assign s_ctrl = '0;
      end
   endgenerate

   assign bus.o_ready = ready;
   assign bus.o_valid = valid;
   assign bus.o_data  = m_data;
   assign bus.o_ctrl  = m_ctrl;
   assign bus.o_count = count;

endmodule

// File: tb/tb_etapa_reg_pipeline.sv
// Drives a skid (SKID=1) and a single-entry (SKID=0) stage with the same
// stimulus and checks both against a small FIFO-occupancy reference model.
module tb_etapa_reg_pipeline;

   logic        clk;
   logic        rs, en, fl, vl, rd;
   logic [31:0] dt;
   logic [3:0]  ct;

   int checks = 0;
   int errors = 0;

   // reference model: up to two queued entries per DUT (index 0: SKID=0, 1: SKID=1)
   int          mcnt [2];
   logic [31:0] mdat [2][2];
   logic [3:0]  mctl [2][2];
   logic [31:0] mlast [2];
   logic        mrdy [2];

   etapa_reg_pipeline_if #(.NBITS(32), .CBITS(4)) bus0 ();
   etapa_reg_pipeline_if #(.NBITS(32), .CBITS(4)) bus1 ();

   assign bus0.i_enable = en;
   assign bus0.i_flush  = fl;
   assign bus0.i_valid  = vl;
   assign bus0.i_data   = dt;
   assign bus0.i_ctrl   = ct;
   assign bus0.i_ready  = rd;
   assign bus1.i_enable = en;
   assign bus1.i_flush  = fl;
   assign bus1.i_valid  = vl;
   assign bus1.i_data   = dt;
   assign bus1.i_ctrl   = ct;
   assign bus1.i_ready  = rd;

   etapa_reg_pipeline #(.NBITS(32), .CBITS(4), .SKID(0)) dut0 (
      .i_clk   (clk),
      .i_reset (rs),
      .bus     (bus0)
   );

   etapa_reg_pipeline #(.NBITS(32), .CBITS(4), .SKID(1)) dut1 (
      .i_clk   (clk),
      .i_reset (rs),
      .bus     (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // compare both DUTs with the model, clock once, then advance the model
   task automatic tick();
      logic [31:0] od;
      logic [3:0]  oc;
      logic        ov, ordy;
      logic [1:0]  ocnt;
      logic        acc, drn;
      #1;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            od = bus0.o_data; oc = bus0.o_ctrl; ov = bus0.o_valid;
            ordy = bus0.o_ready; ocnt = bus0.o_count;
         end else begin
            od = bus1.o_data; oc = bus1.o_ctrl; ov = bus1.o_valid;
            ordy = bus1.o_ready; ocnt = bus1.o_count;
         end
         mrdy[k] = !rs && en && !fl && ((k == 1) ? (mcnt[k] < 2) : (mcnt[k] == 0 || rd));
         chk($sformatf("ready_skid%0d", k), {31'd0, ordy}, {31'd0, mrdy[k]});
         chk($sformatf("valid_skid%0d", k), {31'd0, ov}, (mcnt[k] > 0) ? 32'd1 : 32'd0);
         chk($sformatf("count_skid%0d", k), {30'd0, ocnt}, mcnt[k]);
         chk($sformatf("data_skid%0d", k), od, (mcnt[k] > 0) ? mdat[k][0] : mlast[k]);
         chk($sformatf("ctrl_skid%0d", k), {28'd0, oc}, (mcnt[k] > 0) ? {28'd0, mctl[k][0]} : 32'd0);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         acc = vl && mrdy[k];
         drn = (mcnt[k] > 0) && rd && en && !fl;
         if (rs) begin
            mcnt[k]  = 0;
            mlast[k] = 32'd0;
         end else if (fl) begin
            mcnt[k] = 0;
         end else begin
            if (drn) begin
               mdat[k][0] = mdat[k][1];
               mctl[k][0] = mctl[k][1];
               mcnt[k]--;
            end
            if (acc) begin
               mdat[k][mcnt[k]] = dt;
               mctl[k][mcnt[k]] = ct;
               mcnt[k]++;
            end
         end
         if (mcnt[k] > 0) mlast[k] = mdat[k][0];
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rec [3];
      int          nd;
      int          idx;
      logic        adv;

      rs = 1'b1; en = 1'b1; fl = 1'b0; vl = 1'b1; rd = 1'b0; dt = 32'd0; ct = 4'd0;
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0; mlast[k] = 32'd0; mrdy[k] = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);

      // reset held two cycles with valid input
      tick();
      tick();
      rs = 1'b0;

      // back-to-back stream, one-cycle latency
      rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dt = 32'h10 + i;
         ct = 4'($urandom);
         vl = 1'b1;
         tick();
         chk("stream_data", bus1.o_data, 32'h10 + i);
         chk("stream_valid", {31'd0, bus1.o_valid}, 32'd1);
      end
      vl = 1'b0;
      tick();
      tick();

      // backpressure fills the skid slot
      rd = 1'b0; vl = 1'b1; ct = 4'h5;
      dt = 32'hA1; tick();
      dt = 32'hA2; tick();
      chk("bp_count", {30'd0, bus1.o_count}, 32'd2);
      chk("bp_data", bus1.o_data, 32'hA1);
      chk("bp_ready", {31'd0, bus1.o_ready}, 32'd0);
      vl = 1'b0; rd = 1'b1;
      tick();
      chk("bp_second", bus1.o_data, 32'hA2);
      tick();
      chk("bp_empty", {30'd0, bus1.o_count}, 32'd0);

      // flush from the full state while input is valid
      rd = 1'b0; vl = 1'b1; ct = 4'hF;
      dt = 32'hB1; tick();
      dt = 32'hB2; tick();
      chk("fl_ctrl_before", {28'd0, bus1.o_ctrl}, 32'hF);
      fl = 1'b1; dt = 32'hB3;
      tick();
      chk("fl_valid", {31'd0, bus1.o_valid}, 32'd0);
      chk("fl_ctrl", {28'd0, bus1.o_ctrl}, 32'd0);
      chk("fl_count", {30'd0, bus1.o_count}, 32'd0);
      fl = 1'b0; vl = 1'b0;
      tick();
      chk("fl_dropped", {30'd0, bus1.o_count}, 32'd0);

      // debug step: frozen while enable is low
      rd = 1'b0; vl = 1'b1; ct = 4'h3; dt = 32'hC1;
      tick();
      en = 1'b0; rd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         dt = 32'hC2 + i;
         tick();
         chk("step_data", bus1.o_data, 32'hC1);
         chk("step_count", {30'd0, bus1.o_count}, 32'd1);
      end
      en = 1'b1; dt = 32'hD1;
      tick();
      chk("step_resume", bus1.o_data, 32'hD1);
      vl = 1'b0;
      tick();
      tick();

      // single-entry variant with toggling downstream ready
      nd = 0; idx = 0;
      for (int cyc = 0; cyc < 20 && nd < 3; cyc++) begin
         rd = (cyc % 2 == 0);
         vl = (idx < 3);
         dt = 32'h20 + idx;
         ct = 4'h1;
         #1;
         if (bus0.o_valid) chk("s0_ready_tracks", {31'd0, bus0.o_ready}, {31'd0, rd});
         if (bus0.o_valid && rd) begin
            rec[nd] = bus0.o_data;
            nd++;
         end
         adv = vl && (mcnt[0] == 0 || rd);
         tick();
         if (adv) idx++;
      end
      chk("s0_drained", nd, 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < nd) chk("s0_order", rec[i], 32'h20 + i);
      end
      vl = 1'b0; rd = 1'b1;
      tick();
      tick();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rs = ($urandom_range(0, 49) == 0);
         fl = ($urandom_range(0, 19) == 0);
         en = ($urandom_range(0, 7) != 0);
         vl = 1'($urandom);
         rd = 1'($urandom);
         dt = $urandom;
         ct = 4'($urandom);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/etapa_reg_pipeline.md
ETAPA_REG_PIPELINE -- requirements
Module: etapa_reg_pipeline

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, giving the payload data width in bits.
REQ-002 The block SHALL have parameter CBITS, default 8, giving the control-bit (WB/MEM control) width.
REQ-003 The block SHALL have parameter SKID, default 1: 1 = two-entry skid register; 0 = single-entry register.
REQ-004 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_reset  in  1  reset, synchronous and active-high.
REQ-006 i_enable  in  1  debug-step enable; 0 freezes all state.
REQ-007 i_flush  in  1  discard all held entries and insert a bubble.
REQ-008 i_valid  in  1  upstream entry present.
REQ-009 o_ready  out  1  block accepts an entry this cycle.
REQ-010 i_data  in  NBITS  upstream payload.
REQ-011 i_ctrl  in  CBITS  upstream control bits.
REQ-012 o_valid  out  1  output entry present.
REQ-013 i_ready  in  1  downstream accepts the output entry.
REQ-014 o_data  out  NBITS  head-entry payload.
REQ-015 o_ctrl  out  CBITS  head-entry control bits.
REQ-016 o_count  out  2  occupancy, 0..2.

Function
REQ-017 accept = i_valid & o_ready; drain = o_valid & i_ready & i_enable & ~i_flush.
REQ-018 The FSM SHALL have states EMPTY, ONE and TWO (TWO reachable only when SKID=1); o_count SHALL be 0, 1 or 2 respectively; o_valid SHALL be 1 only in ONE and TWO.
REQ-019 A head register M SHALL drive o_data/o_ctrl; a skid register S SHALL exist only when SKID=1.
REQ-020 When SKID=1, o_ready SHALL be i_enable & ~i_flush & (state != TWO), with no combinational path from i_ready.
REQ-021 When SKID=0, o_ready SHALL be i_enable & ~i_flush & (~o_valid | i_ready).
REQ-022 From EMPTY, accept SHALL load M and move to ONE.
REQ-023 From ONE, accept & drain SHALL load M and stay in ONE.
REQ-024 From ONE, accept & ~drain SHALL load S and move to TWO (SKID=1 only).
REQ-025 From ONE, drain & ~accept SHALL move to EMPTY.
REQ-026 From TWO, drain SHALL copy S to M and move to ONE; no accept is possible in TWO.
REQ-027 Latency SHALL be one cycle: an entry accepted at edge N is visible on the outputs after edge N.
REQ-028 Throughput SHALL be one entry per cycle when i_ready=1 continuously, for both SKID values.
REQ-029 i_enable=0 SHALL hold state, M and S unchanged and force o_ready=0; o_valid, o_data and o_ctrl stay stable.
REQ-030 i_flush=1 SHALL take priority over i_enable, accept and drain: next state EMPTY, M and S control bits cleared to 0, and the input that cycle discarded.
REQ-031 o_ctrl SHALL be all-zero whenever o_valid=0, so a bubble never asserts RegWrite or MemWrite.
REQ-032 o_data SHALL retain its last value when o_valid=0.
REQ-033 Entries SHALL leave in acceptance order; none SHALL be dropped or duplicated except on flush.

Reset
REQ-034 While i_reset=1 on a clock edge: state SHALL go to EMPTY, M and S data and control to 0, o_valid to 0 and o_count to 0.
REQ-035 o_ready SHALL be 0 in any cycle where i_reset=1.
REQ-036 i_reset SHALL take priority over i_flush and i_enable, including mid-transfer.

Structure
REQ-037 Package etapa_pkg SHALL hold the state encoding localparams (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the SKID mode constants.
REQ-038 One sub-module, etapa_reg_entry (NBITS+CBITS register with load and clear-ctrl), SHALL be instantiated for M and, under generate, for S.

Verification
REQ-039 Reset: assert i_reset 2 cycles with i_valid=1 -> o_valid=0, o_ctrl=0, o_count=0, o_ready=0.
REQ-040 Stream (NBITS=32, CBITS=4, SKID=1): i_ready=1, data 0x10..0x13 on 4 cycles -> same values out, 1-cycle latency, no gaps.
REQ-041 Backpressure: SKID=1, i_ready=0 after 0xA1, 0xA2 -> o_count=2, o_ready=0, o_data=0xA1; release i_ready -> 0xA1 then 0xA2 out.
REQ-042 Flush: state TWO with ctrl=4'hF, pulse i_flush while i_valid=1 -> next cycle EMPTY, o_valid=0, o_ctrl=0, input dropped.
REQ-043 Step: i_enable=0 for 3 cycles with i_valid=1 and i_ready=1 -> outputs frozen, o_count unchanged; i_enable=1 -> transfer resumes.
REQ-044 SKID=0: i_ready toggling 1,0,1 with a continuous stream of 0x20..0x22 -> o_ready tracks i_ready combinationally and order is preserved.
